// File: rtl/xadc_chan_averager_if.sv
// Sample stream from the XADC DRP reader plus the AXI-lite register strobes
// and the averager's outputs, bundled as one port.
interface xadc_chan_averager_if;
  logic        sample_valid;
  logic [1:0]  sample_chan;
  logic [15:0] sample_data;
  logic        slv_reg_wren;
  logic [2:0]  axi_awaddr;
  logic [31:0] S_AXI_WDATA;
  logic        slv_reg_rden;
  logic [2:0]  axi_araddr;
  logic [31:0] rd_data;
  logic [3:0]  avg_valid;
  logic        irq;

  modport master (
    output sample_valid, sample_chan, sample_data,
    output slv_reg_wren, axi_awaddr, S_AXI_WDATA,
    output slv_reg_rden, axi_araddr,
    input  rd_data, avg_valid, irq
  );

  modport slave (
    input  sample_valid, sample_chan, sample_data,
    input  slv_reg_wren, axi_awaddr, S_AXI_WDATA,
    input  slv_reg_rden, axi_araddr,
    output rd_data, avg_valid, irq
  );
endinterface

// File: rtl/xadc_chan_averager.sv
// Four-channel block averager for 12-bit XADC results: every 2^AVG_LOG2
// accepted samples of a channel produce a truncated mean, exposed over AXI registers.
module xadc_chan_averager #(
  parameter int AVG_LOG2 = 4
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESETN,
  xadc_chan_averager_if.slave bus
);
  localparam int ACC_W = 12 + AVG_LOG2;

  logic [ACC_W-1:0]    acc_q [4];
  logic [ACC_W-1:0]    acc_d [4];
  logic [AVG_LOG2-1:0] cnt_q [4];
  logic [AVG_LOG2-1:0] cnt_d [4];
  logic [11:0]         avg_q [4];
  logic [11:0]         avg_d [4];
  logic [3:0]          avg_valid_q, avg_valid_d;
  logic [3:0]          done_q, done_d, done_set, done_w1c;
  logic                enable_q, enable_d, irq_en_q, irq_en_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic                wr_ctrl, clr, accept;
  logic [1:0]          ch;
  logic [ACC_W-1:0]    sum;
  logic                unused_bits;

  assign unused_bits = ^{bus.S_AXI_WDATA[31:4], bus.sample_data[3:0]};

  assign ch      = bus.sample_chan;
  assign wr_ctrl = bus.slv_reg_wren && (bus.axi_awaddr == 3'd5);
  // Clear wins over a coincident sample, so the sample is simply not accepted.
  assign clr     = wr_ctrl && bus.S_AXI_WDATA[1];
  assign accept  = bus.sample_valid && enable_q && !clr;
  // Widest sum is 2^AVG_LOG2 * 4095, which still fits in ACC_W bits.
  assign sum     = acc_q[ch] + ACC_W'(bus.sample_data[15:4]);

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    avg_d       = avg_q;
    avg_valid_d = avg_valid_q;
    done_set    = 4'd0;
    if (clr) begin
      for (int i = 0; i < 4; i++) begin
        acc_d[i] = '0;
        cnt_d[i] = '0;
      end
    end else if (accept) begin
      if (&cnt_q[ch]) begin
        avg_d[ch]       = sum[ACC_W-1:AVG_LOG2];
        acc_d[ch]       = '0;
        cnt_d[ch]       = '0;
        avg_valid_d[ch] = 1'b1;
        done_set[ch]    = 1'b1;
      end else begin
        acc_d[ch] = sum;
        cnt_d[ch] = cnt_q[ch] + AVG_LOG2'(1);
      end
    end
  end

  always_comb begin
    done_w1c  = (bus.slv_reg_wren && (bus.axi_awaddr == 3'd4)) ? bus.S_AXI_WDATA[3:0] : 4'd0;
    // A completion on the same edge as its W1C keeps the bit set.
    done_d    = (done_q & ~done_w1c) | done_set;
    enable_d  = wr_ctrl ? bus.S_AXI_WDATA[0] : enable_q;
    irq_en_d  = wr_ctrl ? bus.S_AXI_WDATA[2] : irq_en_q;
    rd_data_d = rd_data_q;
    if (bus.slv_reg_rden) begin
      case (bus.axi_araddr)
        3'd0, 3'd1, 3'd2, 3'd3: rd_data_d = {20'd0, avg_q[bus.axi_araddr[1:0]]};
        3'd4:                   rd_data_d = {28'd0, done_q};
        3'd5:                   rd_data_d = {29'd0, irq_en_q, 1'b0, enable_q};
        default:                rd_data_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
        avg_q[i] <= '0;
      end
      avg_valid_q <= 4'd0;
      done_q      <= 4'd0;
      enable_q    <= 1'b1;
      irq_en_q    <= 1'b0;
      rd_data_q   <= 32'd0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      done_q      <= done_d;
      enable_q    <= enable_d;
      irq_en_q    <= irq_en_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.avg_valid = avg_valid_q;
  assign bus.irq       = irq_en_q & (|done_q);
endmodule

// File: tb/tb_xadc_chan_averager.sv
// Directed bench for xadc_chan_averager: a queue-based reference model checked
// every cycle, plus hand-computed register readbacks at the key points.
module tb_xadc_chan_averager;
  localparam int L = 4;
  localparam int N = 1 << L;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xadc_chan_averager_if bus ();

  xadc_chan_averager #(.AVG_LOG2(L)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .bus           (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: raw sample lists per channel, averaged when full.
  int          q [4][$];
  int          m_avg [4];
  logic [3:0]  m_valid, m_done;
  logic        m_en, m_irqen;
  logic [31:0] m_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0, 3'd1, 3'd2, 3'd3: return 32'(m_avg[a]);
      3'd4:                   return {28'd0, m_done};
      3'd5:                   return {29'd0, m_irqen, 1'b0, m_en};
      default:                return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      m_avg[i] = 0;
    end
    m_valid = 4'd0;
    m_done  = 4'd0;
    m_en    = 1'b1;
    m_irqen = 1'b0;
    m_rd    = 32'd0;
  endtask

  task automatic model_edge();
    logic [3:0] setm, w1c;
    bit clr;
    int c, s;
    setm = 4'd0;
    w1c  = 4'd0;
    if (bus.slv_reg_rden) m_rd = m_read(bus.axi_araddr);
    clr = bus.slv_reg_wren && bus.axi_awaddr == 3'd5 && bus.S_AXI_WDATA[1];
    if (clr) begin
      for (int i = 0; i < 4; i++) q[i].delete();
    end else if (bus.sample_valid && m_en) begin
      c = int'(bus.sample_chan);
      q[c].push_back(int'(bus.sample_data[15:4]));
      if (q[c].size() == N) begin
        s = 0;
        for (int k = 0; k < q[c].size(); k++) s += q[c][k];
        m_avg[c]   = s / N;
        q[c].delete();
        m_valid[c] = 1'b1;
        setm[c]    = 1'b1;
      end
    end
    if (bus.slv_reg_wren && bus.axi_awaddr == 3'd4) w1c = bus.S_AXI_WDATA[3:0];
    m_done = (m_done & ~w1c) | setm;
    if (bus.slv_reg_wren && bus.axi_awaddr == 3'd5) begin
      m_en    = bus.S_AXI_WDATA[0];
      m_irqen = bus.S_AXI_WDATA[2];
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("cyc_rd_data", bus.rd_data, m_rd);
      check("cyc_avg_valid", {28'd0, bus.avg_valid}, {28'd0, m_valid});
      check("cyc_irq", {31'd0, bus.irq}, {31'd0, m_irqen & (|m_done)});
    end
  end

  task automatic drive(input logic sv, input logic [1:0] ch, input logic [15:0] d,
                       input logic wr, input logic [2:0] wa, input logic [31:0] wd,
                       input logic rd, input logic [2:0] ra);
    bus.sample_valid = sv;
    bus.sample_chan  = ch;
    bus.sample_data  = d;
    bus.slv_reg_wren = wr;
    bus.axi_awaddr   = wa;
    bus.S_AXI_WDATA  = wd;
    bus.slv_reg_rden = rd;
    bus.axi_araddr   = ra;
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    bus.slv_reg_wren = 1'b0;
    bus.slv_reg_rden = 1'b0;
  endtask

  task automatic samp(input logic [1:0] ch, input logic [15:0] d, input int n);
    repeat (n) drive(1'b1, ch, d, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    drive(1'b0, 2'd0, 16'd0, 1'b1, a, d, 1'b0, 3'd0);
  endtask

  task automatic rdchk(input string name, input logic [2:0] a, input logic [31:0] exp);
    drive(1'b0, 2'd0, 16'd0, 1'b0, 3'd0, 32'd0, 1'b1, a);
    check(name, bus.rd_data, exp);
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_chan  = 2'd0;
    bus.sample_data  = 16'd0;
    bus.slv_reg_wren = 1'b0;
    bus.axi_awaddr   = 3'd0;
    bus.S_AXI_WDATA  = 32'd0;
    bus.slv_reg_rden = 1'b0;
    bus.axi_araddr   = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_avg_valid", {28'd0, bus.avg_valid}, 32'd0);
    check("rst_irq", {31'd0, bus.irq}, 32'd0);
    check("rst_rd_data", bus.rd_data, 32'd0);
    rst_n = 1'b1;
    rdchk("rst_ctrl", 3'd5, 32'h1);

    // 15 samples do not complete a block; the 16th does.
    samp(2'd0, 16'h8000, 15);
    rdchk("avg0_after15", 3'd0, 32'h0);
    check("avgv_after15", {28'd0, bus.avg_valid}, 32'h0);
    samp(2'd0, 16'h8000, 1);
    check("avgv_after16", {28'd0, bus.avg_valid}, 32'h1);
    rdchk("avg0_after16", 3'd0, 32'h800);
    rdchk("done_after16", 3'd4, 32'h1);

    // Truncation on ch2 with ch1 interleaved.
    for (int i = 0; i < 8; i++) begin
      samp(2'd2, 16'h0000, 1);
      samp(2'd1, 16'h1230, 1);
    end
    for (int i = 0; i < 8; i++) begin
      samp(2'd2, 16'hFFF0, 1);
      samp(2'd1, 16'h1230, 1);
    end
    rdchk("avg2_trunc", 3'd2, 32'h7FF);
    rdchk("avg1_interleave", 3'd1, 32'h123);
    rdchk("avg0_untouched", 3'd0, 32'h800);
    rdchk("done_0111", 3'd4, 32'h7);

    // W1C colliding with a ch3 completion.
    wr(3'd4, 32'h4);
    rdchk("done_0011", 3'd4, 32'h3);
    samp(2'd3, 16'h4560, 15);
    drive(1'b1, 2'd3, 16'h4560, 1'b1, 3'd4, 32'hF, 1'b0, 3'd0);
    rdchk("done_w1c_collide", 3'd4, 32'h8);
    check("irq_masked", {31'd0, bus.irq}, 32'h0);
    wr(3'd5, 32'h5);
    check("irq_enabled", {31'd0, bus.irq}, 32'h1);
    rdchk("avg3", 3'd3, 32'h456);
    wr(3'd4, 32'h8);
    check("irq_after_w1c", {31'd0, bus.irq}, 32'h0);
    wr(3'd5, 32'h1);

    // Clear with a coincident sample.
    samp(2'd0, 16'h1000, 10);
    drive(1'b1, 2'd0, 16'h1000, 1'b1, 3'd5, 32'h3, 1'b0, 3'd0);
    rdchk("ctrl_clear_selfclr", 3'd5, 32'h1);
    rdchk("avg0_retained", 3'd0, 32'h800);
    check("avgv_retained", {28'd0, bus.avg_valid}, 32'hF);
    samp(2'd0, 16'h1000, 15);
    rdchk("avg0_clr15", 3'd0, 32'h800);
    rdchk("done_clr15", 3'd4, 32'h0);
    samp(2'd0, 16'h1000, 1);
    rdchk("avg0_clr16", 3'd0, 32'h100);
    rdchk("done_clr16", 3'd4, 32'h1);

    // Asynchronous reset in the middle of a ch1 block.
    wr(3'd5, 32'h5);
    samp(2'd1, 16'h2000, 12);
    rdchk("avg1_pre_rst", 3'd1, 32'h123);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_avg_valid", {28'd0, bus.avg_valid}, 32'h0);
    check("arst_irq", {31'd0, bus.irq}, 32'h0);
    check("arst_rd_data", bus.rd_data, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdchk("ctrl_after_rst", 3'd5, 32'h1);
    rdchk("avg1_after_rst", 3'd1, 32'h0);
    samp(2'd1, 16'h2000, 15);
    rdchk("avg1_rst15", 3'd1, 32'h0);
    samp(2'd1, 16'h2000, 1);
    rdchk("avg1_rst16", 3'd1, 32'h200);
    check("avgv_rst16", {28'd0, bus.avg_valid}, 32'h2);

    // Disabled: samples ignored; unmapped addresses read zero.
    wr(3'd5, 32'h0);
    samp(2'd2, 16'h3000, 20);
    rdchk("avg2_disabled", 3'd2, 32'h0);
    rdchk("done_disabled", 3'd4, 32'h2);
    check("avgv_disabled", {28'd0, bus.avg_valid}, 32'h2);
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd7, 32'hA5A5_A5A5);
    rdchk("addr6_zero", 3'd6, 32'h0);
    rdchk("addr7_zero", 3'd7, 32'h0);
    wr(3'd5, 32'h1);
    samp(2'd2, 16'h3000, 16);
    rdchk("avg2_reenabled", 3'd2, 32'h300);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/xadc_chan_averager.md
XADC_CHAN_AVERAGER -- requirements
Module: xadc_chan_averager

Interface
REQ-001 SHALL provide parameter AVG_LOG2, default 4, meaning log2 of samples averaged per channel, legal range 1..8.
REQ-002 SHALL provide port S_AXI_ACLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port S_AXI_ARESETN  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port sample_valid  input  1  one-cycle pulse marking a completed XADC DRP read.
REQ-005 SHALL provide port sample_chan  input  2  channel index 0..3 of the sample.
REQ-006 SHALL provide port sample_data  input  16  XADC DRP word; 12-bit result in [15:4].
REQ-007 SHALL provide port slv_reg_wren  input  1  AXI register write strobe.
REQ-008 SHALL provide port axi_awaddr  input  3  AXI write word address.
REQ-009 SHALL provide port S_AXI_WDATA  input  32  AXI write data.
REQ-010 SHALL provide port slv_reg_rden  input  1  AXI register read strobe.
REQ-011 SHALL provide port axi_araddr  input  3  AXI read word address.
REQ-012 SHALL provide port rd_data  output  32  registered read data.
REQ-013 SHALL provide port avg_valid  output  4  per-channel flag: average has been produced since reset.
REQ-014 SHALL provide port irq  output  1  level interrupt.

Function
REQ-015 SHALL keep per channel: accumulator (12+AVG_LOG2 bits, cannot overflow), sample counter (AVG_LOG2 bits), 12-bit average, done_sticky bit.
REQ-016 SHALL, when sample_valid=1 and ctrl.enable=1, add sample_data[15:4] to acc[sample_chan] and increment cnt[sample_chan]; other channels unchanged.
REQ-017 SHALL, when the accepted sample is the 2^AVG_LOG2-th (cnt = all ones), write avg[ch] = (acc+sample)>>AVG_LOG2 (truncating), zero acc and cnt, set avg_valid[ch] and done_sticky[ch], all in the same edge; value readable the following cycle.
REQ-018 SHALL ignore sample_valid while ctrl.enable=0 (acc/cnt hold).
REQ-019 SHALL implement register map: addr 0..3 = {20'b0, avg[ch]} read-only; addr 4 = {28'b0, done_sticky[3:0]}, write-1-to-clear; addr 5 = {29'b0, irq_en, clear, enable} read/write; addr 6..7 read 0, writes ignored.
REQ-020 SHALL make ctrl.clear (bit1) self-clearing: a write with bit1=1 zeroes all acc and cnt on that edge, retains avg and avg_valid, and bit1 reads back 0.
REQ-021 SHALL give clear priority over a simultaneous sample_valid (sample dropped).
REQ-022 SHALL give done_sticky set priority over a simultaneous W1C of the same bit; W1C of other bits still applies.
REQ-023 SHALL load rd_data on the edge where slv_reg_rden=1 from axi_araddr (latency 1); rd_data holds otherwise; simultaneous read of addr 4 with a set returns pre-edge value.
REQ-024 SHALL drive irq = irq_en AND (OR of done_sticky), combinational from registers.

Reset
REQ-025 SHALL, with S_AXI_ARESETN=0, asynchronously clear all acc, cnt, avg, avg_valid, done_sticky, rd_data to 0 and set ctrl = 3'b001 (enable=1, clear=0, irq_en=0); irq=0.
REQ-026 SHALL discard any partial accumulation on reset; first average after release requires a full 2^AVG_LOG2 new samples.

Verification
REQ-027 SHALL test AVG_LOG2=4: 16 pulses ch0, sample_data=16'h8000 -> after 16th edge avg[0]=0x800, avg_valid=4'b0001, addr4 read=0x1; 15 pulses only -> avg[0]=0, avg_valid=0.
REQ-028 SHALL test truncation: ch2 gets 8×16'h0000 then 8×16'hFFF0 -> avg[2]=0x7FF; interleaved ch1 16×16'h1230 in same window -> avg[1]=0x123, no cross-channel effect.
REQ-029 SHALL test W1C collision: write 0xF to addr 4 on same edge ch3 completes, done_sticky previously 4'b0011 -> done_sticky=4'b1000; irq=1 only after addr5 irq_en written 1.
REQ-030 SHALL test clear: ch0 at 10 samples, write addr5=0x3 with coincident sample_valid -> acc/cnt zero, sample dropped, avg[0] retained, addr5 reads 0x1; next average needs 16 fresh samples.
REQ-031 SHALL test reset mid-operation: assert S_AXI_ARESETN low asynchronously (between edges) with ch1 at 12 samples -> all outputs 0 immediately, addr5 reads 0x1 after release, 16 samples needed for avg[1].
REQ-032 SHALL test enable=0 (addr5=0x0): 20 sample pulses -> no state change; read addr 6 -> rd_data=0.
